// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Brief    : Pipeline memory stage. Word loads/stores over a req/resp data
//            port, registered writeback bundle, stall while access pending.
// Revision : 1.0  initial release
// ============================================================================
module mem_stage #(
    parameter int WORD     = 32,
    parameter int ADDR_LEN = 32
) (
    input  logic                clk,
    input  logic                reset,
    // execute-stage bundle
    input  logic                valid_i,
    input  logic [ADDR_LEN-1:0] pc_i,
    input  logic [WORD-1:0]     alu_out_i,
    input  logic [WORD-1:0]     rs2_data_i,
    input  logic [4:0]          rd_addr_i,
    input  logic                rf_w_en_i,
    input  logic [1:0]          wbsel_i,
    input  logic                mem_w_en_i,
    output logic                stall_o,
    // data-memory port
    output logic                dmem_req_o,
    output logic                dmem_we_o,
    output logic [ADDR_LEN-1:0] dmem_addr_o,
    output logic [WORD-1:0]     dmem_wdata_o,
    input  logic                dmem_ready_i,
    input  logic                dmem_rvalid_i,
    input  logic [WORD-1:0]     dmem_rdata_i,
    // writeback bundle
    output logic                wb_valid_o,
    output logic                wb_rf_w_en_o,
    output logic [4:0]          wb_rd_addr_o,
    output logic [WORD-1:0]     wb_data_o,
    output logic [ADDR_LEN-1:0] wb_pc_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] WBSEL_LOAD = 2'b01;
    localparam logic [1:0] WBSEL_LINK = 2'b10;

    state_t              state_q, state_d;

    // holding registers for the in-flight memory instruction
    logic [ADDR_LEN-1:0] pc_q, pc_d;
    logic [ADDR_LEN-1:0] addr_q, addr_d;
    logic [WORD-1:0]     wdata_q, wdata_d;
    logic [4:0]          rd_q, rd_d;
    logic                rfwe_q, rfwe_d;
    logic                store_q, store_d;

    // writeback bundle registers
    logic                wb_valid_q, wb_valid_d;
    logic                wb_rf_w_en_q, wb_rf_w_en_d;
    logic [4:0]          wb_rd_q, wb_rd_d;
    logic [WORD-1:0]     wb_data_q, wb_data_d;
    logic [ADDR_LEN-1:0] wb_pc_q, wb_pc_d;

    logic                is_mem_op;
    logic [ADDR_LEN-1:0] pc_plus4;
    logic [ADDR_LEN-1:0] word_addr;

    assign is_mem_op = valid_i & (mem_w_en_i | (wbsel_i == WBSEL_LOAD));
    assign pc_plus4  = pc_i + ADDR_LEN'(4);
    assign word_addr = {alu_out_i[ADDR_LEN-1:2], 2'b00};

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_d         = rd_q;
        rfwe_d       = rfwe_q;
        store_d      = store_q;
        wb_valid_d   = 1'b0;
        wb_rf_w_en_d = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        wb_pc_d      = wb_pc_q;

        unique case (state_q)
            IDLE: begin
                if (is_mem_op) begin
                    pc_d    = pc_i;
                    addr_d  = word_addr;
                    wdata_d = rs2_data_i;
                    rd_d    = rd_addr_i;
                    rfwe_d  = rf_w_en_i;
                    store_d = mem_w_en_i;
                    state_d = REQ;
                end else if (valid_i) begin
                    wb_valid_d   = 1'b1;
                    wb_rf_w_en_d = rf_w_en_i;
                    wb_rd_d      = rd_addr_i;
                    wb_pc_d      = pc_i;
                    // wbsel 11 is an unused encoding and falls back to ALU
                    wb_data_d    = (wbsel_i == WBSEL_LINK) ? WORD'(pc_plus4) : alu_out_i;
                end
            end
            REQ: begin
                if (dmem_ready_i) begin
                    if (store_q) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_pc_d    = pc_q;
                        state_d    = IDLE;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (dmem_rvalid_i) begin
                    wb_valid_d   = 1'b1;
                    wb_rf_w_en_d = rfwe_q;
                    wb_rd_d      = rd_q;
                    wb_pc_d      = pc_q;
                    wb_data_d    = dmem_rdata_i;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_q         <= '0;
            rfwe_q       <= 1'b0;
            store_q      <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_rf_w_en_q <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            wb_pc_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_q         <= rd_d;
            rfwe_q       <= rfwe_d;
            store_q      <= store_d;
            wb_valid_q   <= wb_valid_d;
            wb_rf_w_en_q <= wb_rf_w_en_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            wb_pc_q      <= wb_pc_d;
        end
    end

    assign stall_o      = (state_q != IDLE);
    assign dmem_req_o   = (state_q == REQ);
    // write strobe only qualifies an active request
    assign dmem_we_o    = (state_q == REQ) & store_q;
    assign dmem_addr_o  = addr_q;
    assign dmem_wdata_o = wdata_q;

    assign wb_valid_o   = wb_valid_q;
    assign wb_rf_w_en_o = wb_rf_w_en_q;
    assign wb_rd_addr_o = wb_rd_q;
    assign wb_data_o    = wb_data_q;
    assign wb_pc_o      = wb_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Brief    : Self-checking bench for mem_stage: vector table, directed
//            multi-cycle sequences and randomized ops against a model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_i;
    logic [31:0] pc_i, alu_out_i, rs2_data_i;
    logic [4:0]  rd_addr_i;
    logic        rf_w_en_i;
    logic [1:0]  wbsel_i;
    logic        mem_w_en_i;
    logic        stall_o;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic        dmem_ready_i, dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic        wb_valid_o, wb_rf_w_en_o;
    logic [4:0]  wb_rd_addr_o;
    logic [31:0] wb_data_o, wb_pc_o;

    int n_chk = 0;
    int n_err = 0;

    // last retired values expected to be held while wb_valid_o is low
    logic [31:0] last_data, last_pc;
    logic [4:0]  last_rd;
    logic        last_data_known, last_rd_known;

    mem_stage #(.WORD(32), .ADDR_LEN(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .valid_i       (valid_i),
        .pc_i          (pc_i),
        .alu_out_i     (alu_out_i),
        .rs2_data_i    (rs2_data_i),
        .rd_addr_i     (rd_addr_i),
        .rf_w_en_i     (rf_w_en_i),
        .wbsel_i       (wbsel_i),
        .mem_w_en_i    (mem_w_en_i),
        .stall_o       (stall_o),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_ready_i  (dmem_ready_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i),
        .wb_valid_o    (wb_valid_o),
        .wb_rf_w_en_o  (wb_rf_w_en_o),
        .wb_rd_addr_o  (wb_rd_addr_o),
        .wb_data_o     (wb_data_o),
        .wb_pc_o       (wb_pc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        rfwe;
        logic [1:0]  wbsel;
        logic [31:0] exp_data;
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference: non-memory writeback value
    function automatic logic [31:0] model_wb(input logic [31:0] pc, input logic [31:0] alu,
                                             input logic [1:0] wbsel);
        return (wbsel == 2'b10) ? pc + 32'd4 : alu;
    endfunction

    task automatic idle_chk();
        valid_i       = 1'b0;
        mem_w_en_i    = 1'($urandom);
        wbsel_i       = 2'b01;
        dmem_ready_i  = 1'b1;
        dmem_rvalid_i = 1'b1;
        step();
        chk("idle_wb_valid", wb_valid_o, 0);
        chk("idle_wb_rfwe", wb_rf_w_en_o, 0);
        chk("idle_stall", stall_o, 0);
        chk("idle_req", dmem_req_o, 0);
        chk("idle_hold_pc", wb_pc_o, last_pc);
        if (last_rd_known)   chk("idle_hold_rd", wb_rd_addr_o, last_rd);
        if (last_data_known) chk("idle_hold_data", wb_data_o, last_data);
    endtask

    // One instruction from acceptance to retirement; rdly/vdly are the extra
    // cycles before ready / rvalid. Returns positioned in the retire cycle.
    task automatic run_op(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rs2,
                          input logic [4:0] rd, input logic rfwe, input logic [1:0] wbsel,
                          input logic st, input int rdly, input int vdly,
                          input logic [31:0] rdata);
        logic is_mem;
        logic [31:0] exp_addr;
        is_mem   = st || (wbsel == 2'b01);
        exp_addr = alu & 32'hFFFF_FFFC;
        chk("accept_stall", stall_o, 0);
        valid_i       = 1'b1;
        pc_i          = pc;
        alu_out_i     = alu;
        rs2_data_i    = rs2;
        rd_addr_i     = rd;
        rf_w_en_i     = rfwe;
        wbsel_i       = wbsel;
        mem_w_en_i    = st;
        dmem_ready_i  = 1'b1;
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = $urandom;
        step();
        if (!is_mem) begin
            valid_i = 1'b0;
            chk("alu_wb_valid", wb_valid_o, 1);
            chk("alu_wb_data", wb_data_o, model_wb(pc, alu, wbsel));
            chk("alu_wb_rd", wb_rd_addr_o, rd);
            chk("alu_wb_pc", wb_pc_o, pc);
            chk("alu_wb_rfwe", wb_rf_w_en_o, rfwe);
            chk("alu_stall", stall_o, 0);
            last_data = model_wb(pc, alu, wbsel);
            last_data_known = 1'b1;
        end else begin
            for (int k = 0; k <= rdly; k++) begin
                valid_i    = 1'($urandom);
                pc_i       = $urandom;
                alu_out_i  = $urandom;
                rs2_data_i = $urandom;
                rd_addr_i  = 5'($urandom);
                mem_w_en_i = 1'($urandom);
                chk("req_req", dmem_req_o, 1);
                chk("req_stall", stall_o, 1);
                chk("req_we", dmem_we_o, st);
                chk("req_addr", dmem_addr_o, exp_addr);
                if (st) chk("req_wdata", dmem_wdata_o, rs2);
                chk("req_wb_valid", wb_valid_o, 0);
                dmem_ready_i  = (k == rdly);
                dmem_rvalid_i = 1'b1;
                dmem_rdata_i  = $urandom;
                step();
            end
            if (!st) begin
                for (int j = 0; j <= vdly; j++) begin
                    chk("resp_req", dmem_req_o, 0);
                    chk("resp_stall", stall_o, 1);
                    chk("resp_wb_valid", wb_valid_o, 0);
                    dmem_ready_i  = 1'b1;
                    dmem_rvalid_i = (j == vdly);
                    dmem_rdata_i  = (j == vdly) ? rdata : $urandom;
                    step();
                end
            end
            valid_i       = 1'b0;
            dmem_ready_i  = 1'b0;
            dmem_rvalid_i = 1'b0;
            chk("mem_wb_valid", wb_valid_o, 1);
            chk("mem_wb_rfwe", wb_rf_w_en_o, st ? 1'b0 : rfwe);
            chk("mem_wb_pc", wb_pc_o, pc);
            chk("mem_stall", stall_o, 0);
            chk("mem_req", dmem_req_o, 0);
            if (!st) begin
                chk("load_wb_rd", wb_rd_addr_o, rd);
                chk("load_wb_data", wb_data_o, rdata);
                last_data = rdata;
                last_data_known = 1'b1;
            end else begin
                last_data_known = 1'b0;
            end
        end
        last_pc       = pc;
        last_rd       = rd;
        last_rd_known = !st;
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{32'h0000_0000, 32'h0000_0004, 5'd5,  1'b1, 2'b00, 32'h0000_0004};
        vecs[1] = '{32'h0000_0100, 32'h1111_1111, 5'd1,  1'b1, 2'b10, 32'h0000_0104};
        vecs[2] = '{32'hFFFF_FFFC, 32'h2222_2222, 5'd1,  1'b1, 2'b10, 32'h0000_0000};
        vecs[3] = '{32'h0000_0040, 32'hCAFE_0003, 5'd9,  1'b1, 2'b11, 32'hCAFE_0003};
        vecs[4] = '{32'h0000_0044, 32'h0000_0077, 5'd12, 1'b0, 2'b00, 32'h0000_0077};
        vecs[5] = '{32'h0000_0048, 32'hABCD_0001, 5'd0,  1'b1, 2'b00, 32'hABCD_0001};

        reset = 1'b1;
        valid_i = 1'b1; pc_i = 32'h10; alu_out_i = 32'h2000; rs2_data_i = 32'h55;
        rd_addr_i = 5'd3; rf_w_en_i = 1'b1; wbsel_i = 2'b01; mem_w_en_i = 1'b1;
        dmem_ready_i = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h99;
        step();
        step();
        chk("rst_stall", stall_o, 0);
        chk("rst_req", dmem_req_o, 0);
        chk("rst_we", dmem_we_o, 0);
        chk("rst_addr", dmem_addr_o, 0);
        chk("rst_wdata", dmem_wdata_o, 0);
        chk("rst_wb_valid", wb_valid_o, 0);
        chk("rst_wb_rfwe", wb_rf_w_en_o, 0);
        chk("rst_wb_rd", wb_rd_addr_o, 0);
        chk("rst_wb_data", wb_data_o, 0);
        chk("rst_wb_pc", wb_pc_o, 0);
        reset = 1'b0; valid_i = 1'b0;
        last_data = '0; last_pc = '0; last_rd = '0;
        last_data_known = 1'b1; last_rd_known = 1'b1;
        idle_chk();

        // table of non-memory vectors with hand-derived writeback data
        for (int i = 0; i < 6; i++) begin
            valid_i = 1'b1; pc_i = vecs[i].pc; alu_out_i = vecs[i].alu;
            rs2_data_i = $urandom; rd_addr_i = vecs[i].rd; rf_w_en_i = vecs[i].rfwe;
            wbsel_i = vecs[i].wbsel; mem_w_en_i = 1'b0;
            dmem_ready_i = 1'b1; dmem_rvalid_i = 1'b1;
            step();
            valid_i = 1'b0;
            chk("vec_wb_valid", wb_valid_o, 1);
            chk("vec_wb_data", wb_data_o, vecs[i].exp_data);
            chk("vec_wb_rd", wb_rd_addr_o, vecs[i].rd);
            chk("vec_wb_rfwe", wb_rf_w_en_o, vecs[i].rfwe);
            chk("vec_stall", stall_o, 0);
            last_data = vecs[i].exp_data; last_pc = vecs[i].pc; last_rd = vecs[i].rd;
            last_data_known = 1'b1; last_rd_known = 1'b1;
        end
        idle_chk();

        // store, ready two cycles late; stall and request span three cycles
        run_op(32'h200, 32'h1006, 32'hDEAD_BEEF, 5'd3, 1'b1, 2'b00, 1'b1, 2, 0, 32'h0);
        idle_chk();
        // load: ready at N+1, rvalid at N+4
        run_op(32'h300, 32'h2000, 32'h0, 5'd7, 1'b1, 2'b01, 1'b0, 0, 2, 32'h1234_5678);
        idle_chk();
        // store with wbsel=01 is a store; back-to-back with a following load
        run_op(32'h304, 32'h3003, 32'h0BAD_F00D, 5'd8, 1'b1, 2'b01, 1'b1, 0, 0, 32'h0);
        run_op(32'h308, 32'h3000, 32'h0, 5'd9, 1'b0, 2'b01, 1'b0, 1, 0, 32'hFEED_0001);
        idle_chk();

        // reset while waiting for load data
        valid_i = 1'b1; pc_i = 32'h400; alu_out_i = 32'h5000; rd_addr_i = 5'd4;
        rf_w_en_i = 1'b1; wbsel_i = 2'b01; mem_w_en_i = 1'b0;
        dmem_ready_i = 1'b0; dmem_rvalid_i = 1'b0;
        step();
        valid_i = 1'b0; dmem_ready_i = 1'b1;
        step();
        chk("rr_in_resp_stall", stall_o, 1);
        chk("rr_in_resp_req", dmem_req_o, 0);
        dmem_ready_i = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rr_req", dmem_req_o, 0);
        chk("rr_stall", stall_o, 0);
        chk("rr_wb_valid", wb_valid_o, 0);
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h7777_7777;
        step();
        dmem_rvalid_i = 1'b0;
        chk("rr_late_rvalid_wb", wb_valid_o, 0);
        chk("rr_late_rvalid_stall", stall_o, 0);
        last_data = '0; last_pc = '0; last_rd = '0;
        last_data_known = 1'b1; last_rd_known = 1'b1;
        run_op(32'h500, 32'h0000_0ABC, 32'h0, 5'd2, 1'b1, 2'b00, 1'b0, 0, 0, 32'h0);
        idle_chk();

        // randomized mix of ALU, link, store and load ops
        for (int i = 0; i < 40; i++) begin
            int kind;
            logic [1:0] ws;
            logic st;
            kind = $urandom_range(0, 3);
            case (kind)
                0:       begin ws = $urandom_range(0, 1) ? 2'b11 : 2'b00; st = 1'b0; end
                1:       begin ws = 2'b10; st = 1'b0; end
                2:       begin ws = 2'($urandom); st = 1'b1; end
                default: begin ws = 2'b01; st = 1'b0; end
            endcase
            run_op($urandom, $urandom, $urandom, 5'($urandom), 1'($urandom), ws, st,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
            if ($urandom_range(0, 1) == 1) idle_chk();
        end
        idle_chk();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory stage of the in-order pipeline: consumes the execute stage's outputs (ALU result, store data, destination register, write-enables, writeback select, PC), performs word loads and stores over a request/response data-memory port, and presents a registered writeback bundle to the register file. Stalls the execute stage with `stall_o` while a memory access is outstanding. Non-memory instructions pass through in one cycle.

## Interface
- `WORD`, 32: data width.
- `ADDR_LEN`, 32: address/PC width.
- `clk`  in  1  clock; everything is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `valid_i`  in  1  execute bundle valid this cycle.
- `pc_i`  in  ADDR_LEN  instruction PC.
- `alu_out_i`  in  WORD  ALU result; this is the address for memory operations.
- `rs2_data_i`  in  WORD  store data.
- `rd_addr_i`  in  5  destination register.
- `rf_w_en_i`  in  1  register-file write enable.
- `wbsel_i`  in  2  writeback source: 00 ALU, 01 load data, 10 pc_i+4, 11 treated as 00.
- `mem_w_en_i`  in  1  store.
- `stall_o`  out  1  upstream must hold its bundle.
- `dmem_req_o`  out  1  memory request.
- `dmem_we_o`  out  1  1 = store.
- `dmem_addr_o`  out  ADDR_LEN  word-aligned address.
- `dmem_wdata_o`  out  WORD  store data.
- `dmem_ready_i`  in  1  request accepted this cycle.
- `dmem_rvalid_i`  in  1  load data valid.
- `dmem_rdata_i`  in  WORD  load data.
- `wb_valid_o`  out  1  one-cycle retire pulse.
- `wb_rf_w_en_o`  out  1  write the register file.
- `wb_rd_addr_o`  out  5  destination register.
- `wb_data_o`  out  WORD  writeback value.
- `wb_pc_o`  out  ADDR_LEN  PC of the retired instruction.

## Operation
- FSM states: IDLE, REQ, RESP.
- A memory op is `valid_i & (mem_w_en_i | wbsel_i==01)`. A store with `wbsel_i==01` is treated as a store.
- IDLE with a non-memory op:
  - Next cycle: `wb_valid_o`=1.
  - `wb_data_o` = `alu_out_i`, or `pc_i+4` (modulo 2^ADDR_LEN) when `wbsel_i==10`.
  - `wb_rf_w_en_o` = `rf_w_en_i`.
  - State stays IDLE.
- IDLE with a memory op:
  - Capture `pc_i`, `rd_addr_i`, `rf_w_en_i`, store flag, address and `rs2_data_i` into holding registers; go to REQ.
  - `dmem_addr_o` = `{alu_out_i[ADDR_LEN-1:2], 2'b00}`. Low two address bits are ignored; there are no byte enables.
- REQ:
  - `dmem_req_o`=1; `dmem_we_o`, `dmem_addr_o` and `dmem_wdata_o` stay stable until `dmem_ready_i`=1.
  - On ready, a store goes to IDLE and pulses `wb_valid_o` next cycle with `wb_rf_w_en_o`=0.
  - On ready, a load goes to RESP.
- RESP:
  - `dmem_req_o`=0.
  - On `dmem_rvalid_i`: go to IDLE; next cycle `wb_valid_o`=1, `wb_data_o` = `dmem_rdata_i`, `wb_rf_w_en_o` = captured `rf_w_en`.
- `dmem_rvalid_i` is ignored outside RESP. `dmem_ready_i` is ignored outside REQ.
- `stall_o` = (state != IDLE), combinational from state.
- `valid_i`=0 in IDLE: `wb_valid_o`=0 next cycle, no state change.
- Writeback fields hold their last value when `wb_valid_o`=0.
- `wb_rf_w_en_o` is forced 0 whenever `wb_valid_o`=0.
- A write to `rd_addr`=0 passes through unchanged; x0 is handled by the register file.

## Timing
- Reset: state IDLE. All outputs 0: `stall_o`, `dmem_req_o`, `dmem_we_o`, `dmem_addr_o`, `dmem_wdata_o`, all `wb_*`.
- ALU op accepted in cycle N: `wb_valid_o` in N+1; no stall.
- Store accepted in N: `dmem_req_o` from N+1. Ready in cycle R gives `wb_valid_o` in R+1. Minimum latency is 2.
- Load accepted in N: ready in cycle R (≥N+1); `rvalid` in cycle V (≥R+1) gives `wb_valid_o` in V+1. Minimum latency is 3.
- `stall_o` is high from N+1 through the cycle that ready (store) or rvalid (load) arrives. The next bundle is accepted in the first cycle `stall_o`=0.
- Back-to-back memory ops are separated by at least one IDLE cycle.
- Reset mid-transaction:
  - The outstanding access is abandoned; `dmem_req_o` drops the cycle after reset is sampled.
  - No `wb_valid_o` pulse is produced for the abandoned instruction.
  - A late `rvalid` arriving in IDLE is ignored.

## Test plan
- ALU pass-through: `alu_out_i`=0x4, `rd`=5, `rf_w_en`=1, `wbsel`=00 -> next cycle `wb_valid_o`=1, `wb_data_o`=0x4, `wb_rd_addr_o`=5, `stall_o` never high.
- JAL link: `pc_i`=0x100, `wbsel`=10 -> `wb_data_o`=0x104; `pc_i`=0xFFFFFFFC -> `wb_data_o`=0x0.
- Store with 2-cycle ready delay: `alu_out`=0x1006, `rs2`=0xDEADBEEF, `mem_w_en`=1:
  - `dmem_addr_o`=0x1004 and `dmem_we_o`=1, stable 3 cycles.
  - `wb_valid_o`=1 with `wb_rf_w_en_o`=0 one cycle after ready.
  - `stall_o` high 3 cycles.
- Load: `alu_out`=0x2000, `wbsel`=01, `rd`=7; ready at N+1; rvalid at N+4 with 0x12345678 -> `wb_valid_o` at N+5 with `wb_data_o`=0x12345678 and `rd`=7. A spurious rvalid during REQ is ignored.
- Reset in RESP: `dmem_req_o`=0, `stall_o`=0 after reset; a following rvalid produces no `wb_valid_o`; the next ALU op retires normally.
